// File: rtl/cia_pkg.sv
// Shared types and defaults for the sequential carry-increment add/sub unit.
package cia_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int BLOCK_DEFAULT = 4;

endpackage

// File: rtl/cia_block.sv
// One carry-increment slice: raw sum with carry 0, bumped by one when cin is set.
module cia_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] s,
    output logic             cout
);

    logic [BLOCK:0] raw;
    logic [BLOCK:0] inc;

    assign raw  = {1'b0, a} + {1'b0, b};
    assign inc  = {1'b0, raw[BLOCK-1:0]} + {{BLOCK{1'b0}}, 1'b1};
    assign s    = cin ? inc[BLOCK-1:0] : raw[BLOCK-1:0];
    assign cout = raw[BLOCK] | (cin & inc[BLOCK]);

endmodule

// File: rtl/cia_addsub_seq.sv
// Sequential adder/subtractor: one BLOCK-bit carry-increment slice per cycle,
// valid/ready on both sides.
module cia_addsub_seq
    import cia_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int BLOCK = BLOCK_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NSLICE = WIDTH / BLOCK;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [BLOCK-1:0] blk_s;
    logic             blk_cout;
    logic             msb_cin;

    // Operands shift right each cycle so the active slice is always the low one.
    cia_block #(
        .BLOCK(BLOCK)
    ) u_block (
        .a    (a_q[BLOCK-1:0]),
        .b    (b_q[BLOCK-1:0]),
        .cin  (c_q),
        .s    (blk_s),
        .cout (blk_cout)
    );

    assign msb_cin = a_q[BLOCK-1] ^ b_q[BLOCK-1] ^ blk_s[BLOCK-1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        acc_d       = acc_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = a;
                    b_d        = b ^ {WIDTH{sub}};
                    c_d        = carry_in ^ sub;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = CALC;
                end
            end
            CALC: begin
                a_d   = a_q >> BLOCK;
                b_d   = b_q >> BLOCK;
                c_d   = blk_cout;
                acc_d = {blk_s, acc_q[WIDTH-1:BLOCK]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d       = '0;
                    sum_d       = acc_d;
                    cout_d      = blk_cout;
                    ovf_d       = msb_cin ^ blk_cout;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= 1'b0;
            acc_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            acc_q       <= acc_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_cia_addsub_seq.sv
// Scoreboard bench for cia_addsub_seq: a 16-bit and a 32-bit instance.
module tb_cia_addsub_seq;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst;

    logic        in_valid, in_ready, sub, carry_in;
    logic        out_valid, out_ready, carry_out, overflow;
    logic [15:0] a, b, sum;

    logic        in_valid32, in_ready32, sub32, carry_in32;
    logic        out_valid32, out_ready32, carry_out32, overflow32;
    logic [31:0] a32, b32, sum32;

    exp_t q16[$];
    exp_t q32[$];

    int tests_run;
    int tests_failed;

    cia_addsub_seq #(.WIDTH(16), .BLOCK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    cia_addsub_seq #(.WIDTH(32), .BLOCK(4)) dut32 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid32),
        .in_ready  (in_ready32),
        .a         (a32),
        .b         (b32),
        .sub       (sub32),
        .carry_in  (carry_in32),
        .out_valid (out_valid32),
        .out_ready (out_ready32),
        .sum       (sum32),
        .carry_out (carry_out32),
        .overflow  (overflow32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic done on 64-bit integers, independent of slicing.
    function automatic exp_t model(int w, logic [31:0] x, logic [31:0] y,
                                   logic s, logic c);
        longint ux, uy, sx, sy, cl, full, r, m;
        exp_t   e;
        m  = (longint'(1) << w) - 1;
        ux = longint'({32'b0, x}) & m;
        uy = longint'({32'b0, y}) & m;
        cl = c ? 1 : 0;
        sx = ux[w-1] ? ux - (m + 1) : ux;
        sy = uy[w-1] ? uy - (m + 1) : uy;
        if (s) begin
            full   = ux - uy - cl;
            e.cout = (ux >= uy + cl);
            r      = sx - sy - cl;
        end else begin
            full   = ux + uy + cl;
            e.cout = full[w];
            r      = sx + sy + cl;
        end
        e.sum = 32'(full & m);
        e.ovf = (r > (m >> 1)) || (r < -((m >> 1) + 1));
        return e;
    endfunction

    task automatic do_op(input logic [15:0] xa, input logic [15:0] xb,
                         input logic xs, input logic xc,
                         input int hold, input logic inject);
        int   n;
        exp_t e;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        a        = xa;
        b        = xb;
        sub      = xs;
        carry_in = xc;
        q16.push_back(model(16, {16'b0, xa}, {16'b0, xb}, xs, xc));
        @(negedge clk);
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        sub      = 1'($urandom);
        carry_in = 1'($urandom);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n !== 4) begin
            tests_failed++;
            $display("FAIL latency: got %0d cycles required 4", n);
        end
        if (q16.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL scoreboard: queue empty, required 1 entry");
            return;
        end
        e = q16.pop_front();
        tests_run++;
        if ({out_valid, sum, carry_out, overflow} !==
            {1'b1, e.sum[15:0], e.cout, e.ovf}) begin
            tests_failed++;
            $display("FAIL result a=%h b=%h sub=%b c=%b: got v=%b s=%h co=%b ov=%b required v=1 s=%h co=%b ov=%b",
                     xa, xb, xs, xc, out_valid, sum, carry_out, overflow,
                     e.sum[15:0], e.cout, e.ovf);
        end
        for (int i = 0; i < hold; i++) begin
            if (inject) begin
                in_valid = 1'b1;
                a        = 16'($urandom);
                b        = 16'($urandom);
            end
            @(negedge clk);
            tests_run++;
            if ({out_valid, in_ready, sum, carry_out, overflow} !==
                {1'b1, 1'b0, e.sum[15:0], e.cout, e.ovf}) begin
                tests_failed++;
                $display("FAIL hold[%0d]: got v=%b rdy=%b s=%h co=%b ov=%b required v=1 rdy=0 s=%h co=%b ov=%b",
                         i, out_valid, in_ready, sum, carry_out, overflow,
                         e.sum[15:0], e.cout, e.ovf);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        tests_run++;
        if ({out_valid, in_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL release: got v=%b rdy=%b required v=0 rdy=1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_valid32  = 1'b0;
        out_ready   = 1'b0;
        out_ready32 = 1'b0;
        a = '0; b = '0; sub = 1'b0; carry_in = 1'b0;
        a32 = '0; b32 = '0; sub32 = 1'b0; carry_in32 = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({in_ready, out_valid, sum, carry_out, overflow} !== {2'b10, 16'h0, 2'b00}) begin
            tests_failed++;
            $display("FAIL reset16: got rdy=%b v=%b s=%h co=%b ov=%b required rdy=1 v=0 s=0000 co=0 ov=0",
                     in_ready, out_valid, sum, carry_out, overflow);
        end
        tests_run++;
        if ({in_ready32, out_valid32, sum32, carry_out32, overflow32} !== {2'b10, 32'h0, 2'b00}) begin
            tests_failed++;
            $display("FAIL reset32: got rdy=%b v=%b s=%h co=%b ov=%b required rdy=1 v=0 s=0 co=0 ov=0",
                     in_ready32, out_valid32, sum32, carry_out32, overflow32);
        end
        rst = 1'b0;
    endtask

    task automatic test_add();
        do_op(16'h1A2B, 16'h3C4D, 1'b0, 1'b0, 0, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b1, 0, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 1, 1'b0);
    endtask

    task automatic test_sub();
        do_op(16'h0005, 16'h0007, 1'b1, 1'b0, 0, 1'b0);
        do_op(16'h0007, 16'h0005, 1'b1, 1'b1, 0, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b1, 1'b0, 0, 1'b0);
        do_op(16'h1234, 16'h1233, 1'b1, 1'b1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        do_op(16'h4321, 16'h1111, 1'b0, 1'b1, 5, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests_run++;
            if ({out_valid, in_ready} !== 2'b01) begin
                tests_failed++;
                $display("FAIL no_accept_in_done[%0d]: got v=%b rdy=%b required v=0 rdy=1",
                         i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        in_valid = 1'b1;
        a = 16'hAAAA; b = 16'h5555; sub = 1'b0; carry_in = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({in_ready, out_valid, sum} !== {2'b10, 16'h0}) begin
            tests_failed++;
            $display("FAIL reset_mid_hold: got rdy=%b v=%b s=%h required rdy=1 v=0 s=0000",
                     in_ready, out_valid, sum);
        end
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        tests_run++;
        if ({seen, in_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL reset_mid: got out_valid_seen=%b rdy=%b required 0 and 1",
                     seen, in_ready);
        end
        do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 2), 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            do_op(16'(16'h1000 * i + 16'h0FFF), 16'(16'h7001 - i), 1'(i), 1'(i >> 1),
                  0, 1'b0);
        end
    endtask

    task automatic test_width32();
        int   n;
        exp_t e;
        logic [31:0] va[2];
        logic [31:0] vb[2];
        va[0] = 32'hFFFF_FFFF; vb[0] = 32'h0000_0001;
        va[1] = 32'h8000_0000; vb[1] = 32'h0000_0001;
        for (int k = 0; k < 2; k++) begin
            in_valid32 = 1'b1;
            a32        = va[k];
            b32        = vb[k];
            sub32      = 1'(k);
            carry_in32 = 1'(k ^ 1);
            q32.push_back(model(32, va[k], vb[k], 1'(k), 1'(k ^ 1)));
            @(negedge clk);
            in_valid32 = 1'b0;
            n = 0;
            while (!out_valid32 && n < 30) begin
                @(negedge clk);
                n++;
            end
            tests_run++;
            if (n !== 8) begin
                tests_failed++;
                $display("FAIL latency32: got %0d cycles required 8", n);
            end
            e = q32.pop_front();
            tests_run++;
            if ({out_valid32, sum32, carry_out32, overflow32} !==
                {1'b1, e.sum, e.cout, e.ovf}) begin
                tests_failed++;
                $display("FAIL result32[%0d]: got v=%b s=%h co=%b ov=%b required v=1 s=%h co=%b ov=%b",
                         k, out_valid32, sum32, carry_out32, overflow32,
                         e.sum, e.cout, e.ovf);
            end
            out_ready32 = 1'b1;
            @(negedge clk);
            out_ready32 = 1'b0;
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        test_width32();
        tests_run++;
        if (q16.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", q16.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cia_addsub_seq.md
CIA_ADDSUB_SEQ -- requirements
Module: cia_addsub_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand/result width; legal values are 16 and 32.
REQ-002 SHALL have parameter BLOCK, default 4, meaning bits processed per cycle; WIDTH SHALL be a multiple of BLOCK.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, meaning the operand set is valid.
REQ-006 SHALL have port in_ready, output, 1, meaning the block can accept operands.
REQ-007 SHALL have ports a and b, input, WIDTH each, meaning operands.
REQ-008 SHALL have port sub, input, 1, meaning 0 selects add and 1 selects subtract.
REQ-009 SHALL have port carry_in, input, 1, meaning carry for add and borrow for subtract.
REQ-010 SHALL have port out_valid, output, 1, meaning the result is valid.
REQ-011 SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-012 SHALL have ports sum (output, WIDTH, result), carry_out (output, 1, carry or not-borrow) and overflow (output, 1, signed overflow).

Function
REQ-013 SHALL implement FSM states IDLE, CALC and DONE.
REQ-014 SHALL assert in_ready only in IDLE; an accept is in_valid&&in_ready on a rising edge.
REQ-015 On accept, SHALL register a, b^{WIDTH{sub}}, sub, and initial carry c0 (carry_in for add, ~carry_in for sub), clear the block counter, and enter CALC.
REQ-016 In CALC, SHALL process one BLOCK-bit slice per cycle, LSB slice first, and register the slice sum and carry into the next slice.
REQ-017 SHALL compute each slice as carry-increment: the slice sum with carry 0, incremented by 1 when the incoming carry is 1.
REQ-018 SHALL remain in CALC for exactly WIDTH/BLOCK cycles, then enter DONE; out_valid SHALL be 1 in the cycle after the last slice (4 cycles after accept for WIDTH=16, 8 for WIDTH=32).
REQ-019 SHALL define the result as follows.
- Add: {carry_out,sum} = a+b+carry_in.
- Sub: sum = a-b-carry_in mod 2^WIDTH.
- Sub: carry_out = 1 iff a >= b+carry_in (unsigned).
REQ-020 SHALL set overflow = carry into MSB XOR carry out of MSB.
REQ-021 In DONE, SHALL hold sum, carry_out, overflow and out_valid stable until out_ready=1, then return to IDLE on that edge.
REQ-022 SHALL ignore in_valid and input changes while in CALC or DONE.
REQ-023 SHALL keep sum, carry_out and overflow at their last values when out_valid=0; they are not meaningful to consumers.

Reset
REQ-024 While rst=1, SHALL force state IDLE, counter 0, and outputs in_ready=1, out_valid=0, sum=0, carry_out=0, overflow=0.
REQ-025 Reset asserted mid-CALC or in DONE SHALL discard the operation; no out_valid SHALL follow.
REQ-026 After rst deassertion, an accept SHALL be possible on the first rising edge.

Structure
REQ-027 SHALL place the state enum (IDLE/CALC/DONE) and the default BLOCK constant in shared package cia_pkg.
REQ-028 SHALL instantiate one combinational sub-module cia_block with BLOCK-bit a, b and cin inputs, producing the carry-increment slice sum and cout.
REQ-029 Counter width SHALL be $clog2(WIDTH/BLOCK) bits, with an explicit terminal compare and no reliance on wrap.

Verification
REQ-030 Add, WIDTH=16: a=1A2B, b=3C4D, cin=0 -> 4 cycles after accept, sum=5678, carry_out=0, overflow=0.
REQ-031 Add, WIDTH=16: a=FFFF, b=0001, cin=1 -> sum=0001, carry_out=1, overflow=0; a=7FFF, b=0001, cin=0 -> sum=8000, overflow=1.
REQ-032 Sub, WIDTH=16: a=0005, b=0007, borrow=0 -> sum=FFFE, carry_out=0; a=0007, b=0005, borrow=1 -> sum=0001, carry_out=1.
REQ-033 Backpressure: out_ready held 0 for 5 cycles -> out_valid, sum and flags stable and in_ready=0 throughout; out_ready=1 -> IDLE next cycle, in_ready=1; a new in_valid during DONE is not accepted.
REQ-034 Reset: rst pulsed 2 cycles after accept -> out_valid never rises, in_ready=1 after release, next operation correct.
REQ-035 WIDTH=32: a=FFFFFFFF, b=00000001, cin=1 -> 8 cycles after accept, sum=00000001, carry_out=1.
